sel_word_packer: RTL
====================

// Module: sel_word_packer
// PURPOSE
//  Encoder side of the 5-bit select-word format {sel, hi[1:0], lo[1:0]}.
//  - The consumer reads a word as: hi when sel=1, lo when sel=0.
//  - This block takes a stream of 2-bit crumbs plus select bits and pairs them into such words.
//  - It packs N_WORDS words into one output bus for the weight/activation loaders.
//  - Valid/ready handshake on both sides, single output register, no bubbles under back-pressure.
// PARAMETERS
//  N_WORDS  4  5-bit select words per output beat (>=1); out_data width = 5*N_WORDS
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            input beat valid
//  in_ready   out  1            input beat accepted when in_valid & in_ready
//  in_crumb   in   2            2-bit field value
//  in_sel     in   1            select bit, sampled only on hi-phase beats
//  in_last    in   1            closes the current word and flushes the partial output
//  out_valid  out  1            out_data/out_count valid
//  out_ready  in   1            downstream accepts when out_valid & out_ready
//  out_data   out  5*N_WORDS    lane k = bits [5k+4:5k]; lane 0 is the first word
//  out_count  out  $clog2(N_WORDS+1)  number of filled lanes, 1..N_WORDS
// BEHAVIOUR
//  Reset values:
//   - out_valid=0, out_data=0, out_count=0.
//   - Phase=LO, lane index=0, staging register cleared.
//   - Reset mid-transfer discards the partial word and any held output.
//  Phase FSM (LO/HI), advances only on an accepted beat:
//   - LO: in_crumb -> staging lo. Next phase is HI, unless in_last=1.
//   - HI: in_crumb -> hi and in_sel -> sel. The word is complete; next phase is LO.
//   - LO beat with in_last=1: word completes immediately with hi=2'b00, sel=0; phase stays LO.
//  Lane fill:
//   - Each completed word is written to the staging lane at the lane index; the index then increments.
//   - Flush condition: the lane index reaches N_WORDS, or the completing beat had in_last=1.
//   - On flush, the output register loads staging; lanes never written are 0.
//   - On flush, out_count = number of filled lanes, lane index -> 0, staging cleared.
//   - in_last on a HI beat: sets in_sel as usual, then flushes.
//  Handshake:
//   - in_ready = !out_valid | out_ready (combinational). The block never drops a completed output.
//   - out_valid rises the cycle after the flushing beat (1-cycle latency).
//   - out_valid, out_data and out_count are stable while out_valid & !out_ready.
//   - Output accepted and a new flush in the same cycle: the new data loads, out_valid stays 1.
//   - Output accepted with no new flush: out_valid -> 0.
//   - When in_ready=0, non-flushing beats also stall; there is no partial acceptance.
//   - in_valid=0 holds all state. in_sel is ignored on LO beats.
//  Width rules:
//   - Lane index width is $clog2(N_WORDS) (min 1).
//   - out_count saturates nowhere; its maximum value is N_WORDS.
// TESTING (N_WORDS=2 unless noted)
//  1. Crumbs 1,2(sel=1),3,0(sel=0), out_ready=1
//     -> out_data=10'b0_00_11_1_10_01, out_count=2, one valid cycle.
//  2. Crumb 2 (in_last) on LO
//     -> out_data lane0=5'b0_00_10, lane1=0, out_count=1; next word starts in LO.
//  3. out_ready=0 for 5 cycles after a flush
//     -> in_ready=0, out_* held stable, no beat accepted; release delivers the data once.
//  4. Continuous stream, out_ready=1
//     -> a flush lands in the same cycle as output acceptance; back-to-back out_valid, no loss or duplication.
//  5. Assert rst mid-HI with out_valid=1
//     -> out_valid=0, out_data=0 immediately; the next beat is treated as LO of lane 0.
//  6. N_WORDS=1: crumbs 3,1 (sel=1)
//     -> out_data=5'b1_01_11, out_count=1.

Source files
------------

// File: rtl/sel_word_packer.sv
// Packs a stream of 2-bit crumbs into N_WORDS select words {sel, hi, lo} per output beat.
// Latency: 1 cycle from the flushing beat; input stalls whenever a held output is not being taken.
module sel_word_packer #(
  parameter int N_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_crumb,
  input  logic                           in_sel,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [5*N_WORDS-1:0]           out_data,
  output logic [$clog2(N_WORDS+1)-1:0]   out_count
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CW = $clog2(N_WORDS + 1);
  localparam int DW = 5 * N_WORDS;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

  typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_t;

  phase_t          phase_q, phase_d;
  logic [1:0]      lo_q, lo_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   stage_q, stage_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_count_q, out_count_d;

  logic            accept;
  logic            complete;
  logic            flush;
  logic [4:0]      word;
  logic [DW-1:0]   filled;

  assign in_ready  = !out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  always_comb begin
    phase_d     = phase_q;
    lo_d        = lo_q;
    idx_d       = idx_q;
    stage_d     = stage_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    complete    = 1'b0;
    word        = 5'd0;

    if (accept) begin
      case (phase_q)
        PH_LO: begin
          // A last beat in LO closes the word with an empty hi half.
          if (in_last) begin
            complete = 1'b1;
            word     = {3'b000, in_crumb};
          end else begin
            lo_d    = in_crumb;
            phase_d = PH_HI;
          end
        end
        default: begin
          complete = 1'b1;
          word     = {in_sel, in_crumb, lo_q};
          phase_d  = PH_LO;
        end
      endcase
    end

    filled = stage_q;
    for (int k = 0; k < N_WORDS; k++) begin
      if (idx_q == IW'(k)) filled[5*k +: 5] = word;
    end

    flush = complete & (in_last | (idx_q == LAST_IDX));

    if (complete) begin
      if (flush) begin
        stage_d = '0;
        idx_d   = '0;
      end else begin
        stage_d = filled;
        idx_d   = idx_q + 1'b1;
      end
    end

    // A new flush may replace an output that is being taken this same cycle.
    if (flush) begin
      out_valid_d = 1'b1;
      out_data_d  = filled;
      out_count_d = CW'(idx_q) + CW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_LO;
      lo_q        <= 2'b00;
      idx_q       <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
